hdc_message_loader: RTL and testbench

Streaming front end for the HDC spam/ham classifier. It accepts one message as a valid/ready stream of 32-bit characters, along with the message's tag (label). It assembles the characters into the fixed 160-entry character buffer, message length and label that the classifier consumes, and starts the classifier. It then returns the classification on a result handshake. It is the hardware-side producer of the classifier's input interface, which the simulation bench currently drives directly from files.

---
 rtl/hdc_pkg.sv | 23 ++
 rtl/hdc_msg_buffer.sv | 29 ++
 rtl/hdc_message_loader.sv | 143 ++++++++++++++
 tb/tb_hdc_message_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared types and sizing for the HDC message loader.
// Buffer geometry, label encoding and loader FSM states.
package hdc_pkg;

  localparam int CHAR_W  = 32;
  localparam int MAX_LEN = 160;
  localparam int LEN_W   = 8;
  localparam int CNT_W   = 16;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  localparam logic LABEL_HAM  = 1'b0;
  localparam logic LABEL_SPAM = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_REPORT
  } ld_state_t;

endpackage

// File: rtl/hdc_msg_buffer.sv
// Character buffer: MAX_LEN x CHAR_W registers with indexed write
// and a single-cycle parallel clear.
module hdc_msg_buffer
  import hdc_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_we,
  input  logic [LEN_W-1:0]          i_idx,
  input  logic [CHAR_W-1:0]         i_data,
  input  logic                      i_clr,
  output logic [MAX_LEN*CHAR_W-1:0] o_data
);

  logic [MAX_LEN-1:0][CHAR_W-1:0] r_mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem <= '0;
    end else if (i_clr) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_idx] <= i_data;
    end
  end

  assign o_data = r_mem;

endmodule

// File: rtl/hdc_message_loader.sv
// Streams one message into the classifier buffer, starts it, reports result.
// Define HDC_ACCURACY_EN to build the saturating accuracy counters.
module hdc_message_loader
  import hdc_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      char_valid,
  output logic                      char_ready,
  input  logic [CHAR_W-1:0]         char_data,
  input  logic                      char_last,
  input  logic                      char_label,
  output logic [MAX_LEN*CHAR_W-1:0] msg_data,
  output logic [LEN_W-1:0]          msg_length,
  output logic                      msg_label,
  output logic                      msg_overflow,
  output logic                      cls_start,
  input  logic                      cls_done,
  input  logic                      cls_result,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_class,
  output logic                      res_label,
  output logic [CNT_W-1:0]          stat_total,
  output logic [CNT_W-1:0]          stat_correct
);

  ld_state_t        r_state, w_next;
  logic [LEN_W-1:0] r_len;
  logic             r_label, r_ovf, r_res_class;
  logic             w_beat, w_we, w_clr, w_done;
  logic [LEN_W-1:0] w_idx;

  assign w_beat = char_valid && char_ready;
  assign w_done = (r_state == S_WAIT) && cls_done;

  always_comb begin
    w_next     = r_state;
    char_ready = 1'b0;
    cls_start  = 1'b0;
    res_valid  = 1'b0;
    w_we       = 1'b0;
    w_idx      = r_len;
    w_clr      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        char_ready = 1'b1;
        w_idx      = '0;
        if (w_beat) begin
          w_we   = 1'b1;
          w_next = char_last ? S_START : S_LOAD;
        end
      end
      S_LOAD: begin
        char_ready = 1'b1;
        if (w_beat) begin
          w_we = (r_len < MAX_LEN_L);
          if (char_last) w_next = S_START;
        end
      end
      S_START: begin
        cls_start = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (cls_done) w_next = S_REPORT;
      end
      S_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_clr  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_label     <= 1'b0;
      r_ovf       <= 1'b0;
      r_res_class <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_beat) begin
        r_len <= LEN_W'(1);
        if (char_last) r_label <= char_label;
      end
      if (r_state == S_LOAD && w_beat) begin
        // Count saturates at MAX_LEN; extra beats only flag overflow.
        if (r_len < MAX_LEN_L) r_len <= r_len + LEN_W'(1);
        else                   r_ovf <= 1'b1;
        if (char_last) r_label <= char_label;
      end
      if (w_done) r_res_class <= cls_result;
      if (w_clr) begin
        r_len <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef HDC_ACCURACY_EN
  logic [CNT_W-1:0] r_total, r_correct;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total   <= '0;
      r_correct <= '0;
    end else if (w_done) begin
      if (r_total != '1) r_total <= r_total + CNT_W'(1);
      if (cls_result == r_label && r_correct != '1)
        r_correct <= r_correct + CNT_W'(1);
    end
  end

  assign stat_total   = r_total;
  assign stat_correct = r_correct;
`else
  assign stat_total   = '0;
  assign stat_correct = '0;
`endif

  hdc_msg_buffer u_buf (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_we),
    .i_idx  (w_idx),
    .i_data (char_data),
    .i_clr  (w_clr),
    .o_data (msg_data)
  );

  assign msg_length   = r_len;
  assign msg_label    = r_label;
  assign msg_overflow = r_ovf;
  assign res_class    = r_res_class;
  assign res_label    = r_label;

endmodule

// File: tb/tb_hdc_message_loader.sv
// Self-checking bench for hdc_message_loader: message table plus
// result scoreboard, with a reset-abort sequence.
module tb_hdc_message_loader;
  import hdc_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      char_valid, char_ready;
  logic [CHAR_W-1:0]         char_data;
  logic                      char_last, char_label;
  logic [MAX_LEN*CHAR_W-1:0] msg_data;
  logic [LEN_W-1:0]          msg_length;
  logic                      msg_label, msg_overflow;
  logic                      cls_start, cls_done, cls_result;
  logic                      res_valid, res_ready, res_class, res_label;
  logic [CNT_W-1:0]          stat_total, stat_correct;

  always #5 clk = ~clk;

  hdc_message_loader dut (
    .clk          (clk),
    .reset        (reset),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .char_data    (char_data),
    .char_last    (char_last),
    .char_label   (char_label),
    .msg_data     (msg_data),
    .msg_length   (msg_length),
    .msg_label    (msg_label),
    .msg_overflow (msg_overflow),
    .cls_start    (cls_start),
    .cls_done     (cls_done),
    .cls_result   (cls_result),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_class    (res_class),
    .res_label    (res_label),
    .stat_total   (stat_total),
    .stat_correct (stat_correct)
  );

  typedef struct {
    int               n;
    int               nd;
    logic [2:0][31:0] d;
    logic [31:0]      base;
    bit               label;
    bit               result;
    int               delay;
    int               hold;
    int               exp_len;
    bit               exp_ovf;
  } vec_t;

  typedef struct {
    bit cls;
    bit lbl;
    int total;
    int correct;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_total = 0;
  int   exp_correct = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] beat(input vec_t v, input int i);
    if (i < v.nd) return v.d[i];
    return v.base + 32'(i);
  endfunction

  function automatic logic [31:0] entry(input int k);
    return msg_data[k*CHAR_W +: CHAR_W];
  endfunction

  task automatic check_buf(input string nm, input vec_t v, input int len);
    int bad = 0;
    for (int k = 0; k < MAX_LEN; k++) begin
      logic [31:0] e;
      e = (k < len) ? beat(v, k) : 32'h0;
      if (entry(k) !== e) bad++;
    end
    chk(nm, 32'(bad), 32'h0);
  endtask

  task automatic send(input vec_t v);
    int bad = 0;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      char_valid = 1'b1;
      char_data  = beat(v, i);
      char_last  = (i == v.n - 1);
      char_label = v.label;
      if (char_ready !== 1'b1) bad++;
      @(posedge clk);
    end
    @(negedge clk);
    char_valid = 1'b0;
    char_last  = 1'b0;
    chk("ready_during_load", 32'(bad), 32'h0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   w;
    int   bad;
    exp_total++;
    if (v.result == v.label) exp_correct++;
    e.cls = v.result;
    e.lbl = v.label;
`ifdef HDC_ACCURACY_EN
    e.total   = exp_total;
    e.correct = exp_correct;
`else
    e.total   = 0;
    e.correct = 0;
`endif
    sb.push_back(e);
    send(v);
    chk("cls_start", 32'(cls_start), 32'h1);
    chk("msg_length", 32'(msg_length), 32'(v.exp_len));
    chk("msg_overflow", 32'(msg_overflow), 32'(v.exp_ovf));
    chk("msg_label", 32'(msg_label), 32'(v.label));
    check_buf("buf_loaded", v, v.exp_len);
    @(negedge clk);
    chk("cls_start_once", 32'(cls_start), 32'h0);
    repeat (v.delay - 1) @(negedge clk);
    cls_done   = 1'b1;
    cls_result = v.result;
    @(negedge clk);
    cls_done   = 1'b0;
    w = 0;
    while (!res_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (res_valid !== 1'b1) begin
      chk("res_valid_timeout", 32'(res_valid), 32'h1);
      return;
    end
    chk("res_latency", 32'(w), 32'h0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'h0, 32'h1);
      return;
    end
    e = sb.pop_front();
    chk("res_class", 32'(res_class), 32'(e.cls));
    chk("res_label", 32'(res_label), 32'(e.lbl));
    chk("stat_total", 32'(stat_total), 32'(e.total));
    chk("stat_correct", 32'(stat_correct), 32'(e.correct));
    if (v.hold > 0) begin
      bad = 0;
      repeat (v.hold) begin
        @(negedge clk);
        if (res_valid !== 1'b1 || res_class !== e.cls ||
            char_ready !== 1'b0 || msg_length !== LEN_W'(v.exp_len))
          bad++;
      end
      chk("report_hold", 32'(bad), 32'h0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("idle_ready", 32'(char_ready), 32'h1);
    chk("idle_res_valid", 32'(res_valid), 32'h0);
    chk("len_cleared", 32'(msg_length), 32'h0);
    chk("ovf_cleared", 32'(msg_overflow), 32'h0);
    check_buf("buf_cleared", v, 0);
  endtask

  task automatic check_reset_state(input string nm);
    int bad = 0;
    if (char_ready !== 1'b1) bad++;
    if (msg_length !== '0) bad++;
    if (msg_label !== 1'b0) bad++;
    if (msg_overflow !== 1'b0) bad++;
    if (cls_start !== 1'b0) bad++;
    if (res_valid !== 1'b0) bad++;
    if (res_class !== 1'b0) bad++;
    if (res_label !== 1'b0) bad++;
    if (stat_total !== '0) bad++;
    if (stat_correct !== '0) bad++;
    if (msg_data !== '0) bad++;
    chk(nm, 32'(bad), 32'h0);
  endtask

  initial begin
    vec_t r;
    int   bad;
    vecs[0] = '{n:3, nd:3, d:{32'h21, 32'h69, 32'h48}, base:32'h0,
                label:1'b1, result:1'b1, delay:4, hold:0,
                exp_len:3, exp_ovf:1'b0};
    vecs[1] = '{n:1, nd:1, d:{32'h0, 32'h0, 32'h55}, base:32'h0,
                label:1'b0, result:1'b1, delay:2, hold:0,
                exp_len:1, exp_ovf:1'b0};
    vecs[2] = '{n:170, nd:0, d:'0, base:32'hA000,
                label:1'b1, result:1'b0, delay:1, hold:0,
                exp_len:160, exp_ovf:1'b1};
    vecs[3] = '{n:5, nd:0, d:'0, base:32'h7700,
                label:1'b0, result:1'b0, delay:3, hold:10,
                exp_len:5, exp_ovf:1'b0};
    vecs[4] = '{n:160, nd:0, d:'0, base:32'h3100,
                label:1'b0, result:1'b1, delay:2, hold:0,
                exp_len:160, exp_ovf:1'b0};

    reset      = 1'b1;
    char_valid = 1'b0;
    char_data  = '0;
    char_last  = 1'b0;
    char_label = 1'b0;
    cls_done   = 1'b0;
    cls_result = 1'b0;
    res_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset_state");

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort during WAIT, then a stale cls_done must be ignored.
    r = '{n:2, nd:0, d:'0, base:32'h9900, label:1'b1, result:1'b1,
          delay:1, hold:0, exp_len:2, exp_ovf:1'b0};
    send(r);
    chk("abort_start", 32'(cls_start), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    cls_done   = 1'b1;
    cls_result = 1'b1;
    check_reset_state("abort_reset_state");
    @(negedge clk);
    cls_done = 1'b0;
    bad = 0;
    repeat (5) begin
      if (res_valid !== 1'b0 || char_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("abort_stale_done", 32'(bad), 32'h0);
    check_reset_state("abort_idle_state");
    exp_total   = 0;
    exp_correct = 0;
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
